// File: rtl/operand_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | operand_loader                                                           |
// | Debounces PB1..PB4 and loads the synchronized switch nibble into a/b.    |
// | Option macro: OPERAND_LOADER_ACTIVE_LOW_EN (pull-up buttons, press = 0). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic       PB4,
  input  logic [3:0] y,
  input  logic       clr,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [3:0] pb_level,
  output logic [3:0] mask,
  output logic       valid,
  output logic       load_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] pb_raw;
  logic [3:0] pb_s1, pb_s2;
  logic [3:0] y_s1, y_s2;
  logic [3:0] level;
  logic [3:0] pb_prev;
  logic [3:0] strobe;
  logic [7:0] a_nxt, b_nxt;
  logic [3:0] mask_nxt;

`ifdef OPERAND_LOADER_ACTIVE_LOW_EN
  assign pb_raw = ~{PB4, PB3, PB2, PB1};
`else
  assign pb_raw = {PB4, PB3, PB2, PB1};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_s1 <= '0;
      pb_s2 <= '0;
      y_s1  <= '0;
      y_s2  <= '0;
    end else begin
      pb_s1 <= pb_raw;
      pb_s2 <= pb_s1;
      y_s1  <= y;
      y_s2  <= y_s1;
    end
  end

  // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (pb_s2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        lvl <= pb_s2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign level[i] = lvl;
  end

  assign pb_level = level;
  assign strobe   = level & ~pb_prev;

  always_comb begin
    a_nxt    = a;
    b_nxt    = b;
    mask_nxt = mask;
    if (clr) begin
      a_nxt    = '0;
      b_nxt    = '0;
      mask_nxt = '0;
    end else begin
      if (strobe[0]) a_nxt[3:0] = y_s2;
      if (strobe[1]) a_nxt[7:4] = y_s2;
      if (strobe[2]) b_nxt[3:0] = y_s2;
      if (strobe[3]) b_nxt[7:4] = y_s2;
      mask_nxt = mask | strobe;
    end
  end

  // load_done fires only on the incomplete-to-complete transition of the mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_prev   <= '0;
      a         <= '0;
      b         <= '0;
      mask      <= '0;
      valid     <= 1'b0;
      load_done <= 1'b0;
    end else begin
      pb_prev   <= level;
      a         <= a_nxt;
      b         <= b_nxt;
      mask      <= mask_nxt;
      valid     <= &mask_nxt;
      load_done <= (&mask_nxt) & ~(&mask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// Directed self-checking bench for operand_loader (DEBOUNCE_CYCLES = 16).
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb;
  logic [3:0] y;
  logic       clr;
  logic [7:0] a, b;
  logic [3:0] pb_level, mask;
  logic       valid, load_done;

  int errors = 0;
  int checks = 0;
  int ld_cnt = 0;
  bit seen_hi;

  operand_loader #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .PB1(pb[0]), .PB2(pb[1]), .PB3(pb[2]), .PB4(pb[3]),
    .y(y), .clr(clr),
    .a(a), .b(b), .pb_level(pb_level), .mask(mask),
    .valid(valid), .load_done(load_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 ns later.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      ld_cnt += int'(load_done);
    end
  endtask

  task automatic press(input logic [3:0] btns, input logic [3:0] nib);
    y  = nib;
    pb = btns;
    tick(25);
    pb = 4'b0000;
    tick(25);
  endtask

  initial begin
    rst = 1'b1; pb = 4'b0000; y = 4'h0; clr = 1'b0;
    tick(3);
    chk("reset_ab", {a, b}, 16'h0000);
    chk("reset_mask_level", {mask, pb_level}, 8'h00);
    chk("reset_valid_done", {valid, load_done}, 2'b00);
    rst = 1'b0;
    tick(3);

    // Clean press of PB1 with y=A
    y = 4'hA; pb = 4'b0001;
    tick(17);
    chk("clean_level_e17", pb_level, 4'b0000);
    tick(1);
    chk("clean_level_e18", pb_level, 4'b0001);
    chk("clean_mask_e18", mask, 4'b0000);
    tick(1);
    chk("clean_a_e19", a, 8'h0A);
    chk("clean_mask_e19", mask, 4'b0001);
    y = 4'h5;
    tick(21);
    pb = 4'b0000;
    tick(30);
    chk("clean_no_reload", a, 8'h0A);
    chk("clean_release_level", pb_level, 4'b0000);
    chk("clean_no_done", ld_cnt, 0);

    // Bounce on PB2: toggle every 5 cycles, then hold
    y = 4'h3; seen_hi = 1'b0;
    for (int s = 0; s < 12; s++) begin
      pb[1] = (s % 2 == 0);
      for (int k = 0; k < 5; k++) begin
        tick(1);
        if (mask[1] || pb_level[1]) seen_hi = 1'b1;
      end
    end
    chk("bounce_no_load", {31'd0, seen_hi}, 0);
    pb[1] = 1'b1;
    tick(18);
    chk("bounce_mask_e18", mask, 4'b0001);
    tick(1);
    chk("bounce_a_e19", a, 8'h3A);
    chk("bounce_mask_e19", mask, 4'b0011);
    y = 4'h7;
    tick(10);
    pb[1] = 1'b0;
    tick(30);
    chk("bounce_once", a, 8'h3A);

    // Clear then full load
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_abm", {a, b, 4'h0, mask}, 24'h0);
    ld_cnt = 0;
    press(4'b0001, 4'h1);
    press(4'b0010, 4'h2);
    press(4'b0100, 4'h3);
    chk("full_not_valid_3", {valid, ld_cnt[0]}, 2'b00);
    press(4'b1000, 4'h4);
    chk("full_a", a, 8'h21);
    chk("full_b", b, 8'h43);
    chk("full_mask_valid", {mask, 3'b000, valid}, 8'hF1);
    chk("full_done_once", ld_cnt, 1);

    // Reload PB1 after complete
    ld_cnt = 0;
    press(4'b0001, 4'hF);
    chk("reload_a", a, 8'h2F);
    chk("reload_valid", valid, 1'b1);
    chk("reload_no_done", ld_cnt, 0);

    // PB3+PB4 strobes coincide with clr
    y = 4'h5; pb = 4'b1100;
    tick(18);
    chk("clrwin_level", pb_level, 4'b1100);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clrwin_ab", {a, b}, 16'h0000);
    chk("clrwin_mask_valid", {mask, valid}, 5'b00000);
    tick(10);
    pb = 4'b0000;
    tick(25);
    chk("clrwin_no_done", ld_cnt, 0);
    chk("clrwin_mask_after", mask, 4'b0000);
    press(4'b1100, 4'h9);
    chk("pair_b", b, 8'h99);
    chk("pair_a", a, 8'h00);
    chk("pair_mask", {mask, valid}, 5'b11000);

    // Async reset mid-window with PB1 held
    y = 4'h6; pb = 4'b0001;
    tick(10);
    rst = 1'b1;
    #1;
    chk("arst_ab", {a, b}, 16'h0000);
    chk("arst_mask_level", {mask, pb_level}, 8'h00);
    chk("arst_valid_done", {valid, load_done}, 2'b00);
    #2;
    rst = 1'b0;
    tick(17);
    chk("arst_level_e17", pb_level, 4'b0000);
    tick(1);
    chk("arst_level_e18", pb_level, 4'b0001);
    chk("arst_mask_e18", mask, 4'b0000);
    tick(1);
    chk("arst_a_e19", a, 8'h06);
    chk("arst_mask_e19", mask, 4'b0001);
    pb = 4'b0000;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
